// File: rtl/alu_muldiv_seq_if.sv
// Bundle between the MULTU/DIVU sequencer, the execute-stage command side and
// the shared ALU arbiter/datapath.
interface alu_muldiv_seq_if;
  logic        start;
  logic        op_div;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        alu_req;
  logic        alu_gnt;
  logic [3:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  start, op_div, rs_val, rt_val, alu_gnt, alu_result,
    output alu_req, alu_control, alu_a, alu_b, alu_shamt,
           busy, done, div_by_zero, hi, lo
  );

  modport master (
    output start, op_div, rs_val, rt_val, alu_gnt, alu_result,
    input  alu_req, alu_control, alu_a, alu_b, alu_shamt,
           busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// MULTU/DIVU sequencer: shift-add multiply and restoring divide, one borrowed
// ALU add/subtract per iteration, results kept in HI/LO.
//
// state  | meaning
// S_IDLE | waiting for start; HI/LO/div_by_zero hold last result
// S_MUL  | shift-add iterations, ALU requested only when lo[0]=1
// S_DIV  | restoring-divide iterations, ALU requested every iteration
// S_DONE | one-cycle completion pulse
module alu_muldiv_seq #(
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input logic             clk,
  input logic             rst_n,
  alu_muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] hi_q, hi_nxt;
  logic [31:0] lo_q, lo_nxt;
  logic [31:0] opnd_q, opnd_nxt;
  logic [4:0]  cnt_q, cnt_nxt;
  logic        dbz_q, dbz_nxt;

  logic [31:0] div_r;
  logic        div_c;
  logic        carry;
  logic        ge;
  logic        iter_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      opnd_q <= opnd_nxt;
      cnt_q  <= cnt_nxt;
      dbz_q  <= dbz_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    hi_nxt          = hi_q;
    lo_nxt          = lo_q;
    opnd_nxt        = opnd_q;
    cnt_nxt         = cnt_q;
    dbz_nxt         = dbz_q;
    iter_done       = 1'b0;
    bus.alu_req     = 1'b0;
    bus.alu_control = 4'b0000;
    bus.alu_a       = '0;
    bus.alu_b       = '0;

    // Carry/borrow recovered from unsigned compares so the ALU stays untouched.
    div_r = {hi_q[30:0], lo_q[31]};
    div_c = hi_q[31];
    carry = (bus.alu_result < hi_q);
    ge    = div_c | (bus.alu_result <= div_r);

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          dbz_nxt = 1'b0;
          cnt_nxt = '0;
          if (!bus.op_div) begin
            state_nxt = S_MUL;
            hi_nxt    = '0;
            lo_nxt    = bus.rt_val;
            opnd_nxt  = bus.rs_val;
          end else if (bus.rt_val != 32'd0) begin
            state_nxt = S_DIV;
            hi_nxt    = '0;
            lo_nxt    = bus.rs_val;
            opnd_nxt  = bus.rt_val;
          end else begin
            state_nxt = S_DONE;
            hi_nxt    = bus.rs_val;
            lo_nxt    = 32'hFFFF_FFFF;
            dbz_nxt   = 1'b1;
          end
        end
      end

      S_MUL: begin
        if (lo_q[0]) begin
          bus.alu_req     = 1'b1;
          bus.alu_control = ALU_ADD;
          bus.alu_a       = hi_q;
          bus.alu_b       = opnd_q;
          if (bus.alu_gnt) begin
            hi_nxt    = {carry, bus.alu_result[31:1]};
            lo_nxt    = {bus.alu_result[0], lo_q[31:1]};
            iter_done = 1'b1;
          end
        end else begin
          hi_nxt    = {1'b0, hi_q[31:1]};
          lo_nxt    = {hi_q[0], lo_q[31:1]};
          iter_done = 1'b1;
        end
      end

      S_DIV: begin
        bus.alu_req     = 1'b1;
        bus.alu_control = ALU_SUB;
        bus.alu_a       = div_r;
        bus.alu_b       = opnd_q;
        if (bus.alu_gnt) begin
          hi_nxt    = ge ? bus.alu_result : div_r;
          lo_nxt    = {lo_q[30:0], ge};
          iter_done = 1'b1;
        end
      end

      S_DONE: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase

    if (iter_done) begin
      cnt_nxt = cnt_q + 5'd1;
      if (cnt_q == 5'd31) state_nxt = S_DONE;
    end
  end

  assign bus.alu_shamt   = 5'd0;
  assign bus.busy        = (state == S_MUL) || (state == S_DIV);
  assign bus.done        = (state == S_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
